rob: RTL and testbench

//  Reorder buffer: circular queue of in-flight instructions sitting downstream of the reservation

---
 rtl/rob_pkg.sv | 36 +++
 rtl/rob_if.sv | 65 ++++++
 rtl/rob.sv | 188 ++++++++++++++++++
 tb/tb_rob.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// ============================================================================
// rob_pkg: shared constants, type encodings and entry layout for the reorder buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package rob_pkg;

  localparam int ROB_WIDTH     = 16;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int REG_ID_BIT    = 5;

  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;
  typedef logic [REG_ID_BIT-1:0]    reg_id_t;

  typedef enum logic [1:0] {
    ROB_T_REG  = 2'd0,
    ROB_T_BR   = 2'd1,
    ROB_T_JALR = 2'd2,
    ROB_T_ST   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   rtype;
    reg_id_t     rd;
    logic [31:0] value;
    logic        pred_taken;
    logic [31:0] alt_pc;
    logic [31:0] jalr_pc;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_if.sv
// ============================================================================
// rob_if: decoder / rs / lsb / commit signal bundle around the reorder buffer
// Rev 1.0
// ============================================================================
`default_nettype none

interface rob_if;
  import rob_pkg::*;

  logic        rob_full;
  logic        issue_valid;
  logic [1:0]  issue_type;
  reg_id_t     issue_rd;
  logic        issue_pred_taken;
  logic [31:0] issue_alt_pc;
  rob_id_t     alloc_id;

  rob_id_t     qry_j_id;
  rob_id_t     qry_k_id;
  logic        qry_j_rdy;
  logic        qry_k_rdy;
  logic [31:0] qry_j_val;
  logic [31:0] qry_k_val;

  logic        rs_to_rob;
  rob_id_t     rs_rob_id;
  logic [31:0] rs_value;
  logic [31:0] rs_new_pc;
  logic        lsb_to_rob;
  rob_id_t     lsb_rob_id;
  logic [31:0] lsb_value;

  logic        commit_reg;
  reg_id_t     commit_rd;
  logic [31:0] commit_value;
  rob_id_t     commit_rob_id;
  logic        commit_store;
  logic        clear_all;
  logic [31:0] new_pc;

  modport slave (
    output rob_full, alloc_id,
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  qry_j_id, qry_k_id,
    output qry_j_rdy, qry_k_rdy, qry_j_val, qry_k_val,
    input  rs_to_rob, rs_rob_id, rs_value, rs_new_pc,
    input  lsb_to_rob, lsb_rob_id, lsb_value,
    output commit_reg, commit_rd, commit_value, commit_rob_id, commit_store,
    output clear_all, new_pc
  );

  modport master (
    input  rob_full, alloc_id,
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output qry_j_id, qry_k_id,
    input  qry_j_rdy, qry_k_rdy, qry_j_val, qry_k_val,
    output rs_to_rob, rs_rob_id, rs_value, rs_new_pc,
    output lsb_to_rob, lsb_rob_id, lsb_value,
    input  commit_reg, commit_rd, commit_value, commit_rob_id, commit_store,
    input  clear_all, new_pc
  );

endinterface

`default_nettype wire

// File: rtl/rob.sv
// ============================================================================
// rob: in-order allocate / out-of-order writeback / in-order retire reorder buffer.
// Optional ROB_BYPASS_EN: operand queries also see same-cycle rs/lsb writebacks.
// Rev 1.0
// ============================================================================
`default_nettype none

module rob
  import rob_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   rdy_in,
  rob_if.slave   bus
);

  localparam logic [ROB_WIDTH_BIT:0] SIZE_FULL = (ROB_WIDTH_BIT+1)'(ROB_WIDTH);

  rob_entry_t                 entries_q [ROB_WIDTH];
  rob_entry_t                 entries_d [ROB_WIDTH];
  rob_id_t                    head_q, head_d;
  rob_id_t                    tail_q, tail_d;
  logic [ROB_WIDTH_BIT:0]     size_q, size_d;

  logic        commit_reg_q,    commit_reg_d;
  logic        commit_store_q,  commit_store_d;
  logic        clear_all_q,     clear_all_d;
  reg_id_t     commit_rd_q,     commit_rd_d;
  logic [31:0] commit_value_q,  commit_value_d;
  rob_id_t     commit_rob_id_q, commit_rob_id_d;
  logic [31:0] new_pc_q,        new_pc_d;

  rob_entry_t  head_entry;
  logic        full;
  logic        alloc_fire;
  logic        commit_fire;
  logic        redirect;
  logic        flush;

  assign head_entry  = entries_q[head_q];
  assign full        = (size_q == SIZE_FULL);
  assign alloc_fire  = rdy_in & bus.issue_valid & ~full;
  assign commit_fire = rdy_in & head_entry.busy & head_entry.ready;
  // jalr always redirects because fetch stalls behind it
  assign redirect    = (head_entry.rtype == ROB_T_JALR) ||
                       ((head_entry.rtype == ROB_T_BR) &&
                        (head_entry.value[0] != head_entry.pred_taken));
  assign flush       = commit_fire & redirect;

  function automatic logic [32:0] query(input rob_id_t id);
    logic        rdy;
    logic [31:0] val;
    rdy = entries_q[id].busy & entries_q[id].ready;
    val = entries_q[id].value;
`ifdef ROB_BYPASS_EN
    if (rdy_in && bus.rs_to_rob && (bus.rs_rob_id == id) && entries_q[id].busy) begin
      rdy = 1'b1;
      val = bus.rs_value;
    end
    if (rdy_in && bus.lsb_to_rob && (bus.lsb_rob_id == id) && entries_q[id].busy) begin
      rdy = 1'b1;
      val = bus.lsb_value;
    end
`endif
    return {rdy, val};
  endfunction

  always_comb begin
    {bus.qry_j_rdy, bus.qry_j_val} = query(bus.qry_j_id);
    {bus.qry_k_rdy, bus.qry_k_val} = query(bus.qry_k_id);
  end

  assign bus.rob_full      = full;
  assign bus.alloc_id      = tail_q;
  assign bus.commit_reg    = commit_reg_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_value  = commit_value_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.commit_store  = commit_store_q;
  assign bus.clear_all     = clear_all_q;
  assign bus.new_pc        = new_pc_q;

  always_comb begin
    entries_d       = entries_q;
    head_d          = head_q;
    tail_d          = tail_q;
    size_d          = size_q;
    commit_reg_d    = rdy_in ? 1'b0 : commit_reg_q;
    commit_store_d  = rdy_in ? 1'b0 : commit_store_q;
    clear_all_d     = rdy_in ? 1'b0 : clear_all_q;
    commit_rd_d     = commit_rd_q;
    commit_value_d  = commit_value_q;
    commit_rob_id_d = commit_rob_id_q;
    new_pc_d        = new_pc_q;

    if (rdy_in) begin
      if (bus.rs_to_rob && entries_q[bus.rs_rob_id].busy) begin
        entries_d[bus.rs_rob_id].ready   = 1'b1;
        entries_d[bus.rs_rob_id].value   = bus.rs_value;
        entries_d[bus.rs_rob_id].jalr_pc = bus.rs_new_pc;
      end
      if (bus.lsb_to_rob && entries_q[bus.lsb_rob_id].busy) begin
        entries_d[bus.lsb_rob_id].ready = 1'b1;
        entries_d[bus.lsb_rob_id].value = bus.lsb_value;
      end

      if (alloc_fire) begin
        entries_d[tail_q] = '{busy:       1'b1,
                              ready:      1'b0,
                              rtype:      rob_type_e'(bus.issue_type),
                              rd:         bus.issue_rd,
                              value:      32'd0,
                              pred_taken: bus.issue_pred_taken,
                              alt_pc:     bus.issue_alt_pc,
                              jalr_pc:    32'd0};
        tail_d = tail_q + 1'b1;
      end

      if (commit_fire) begin
        entries_d[head_q].busy  = 1'b0;
        entries_d[head_q].ready = 1'b0;
        head_d          = head_q + 1'b1;
        commit_rob_id_d = head_q;
        commit_rd_d     = head_entry.rd;
        commit_value_d  = head_entry.value;
        commit_reg_d    = ((head_entry.rtype == ROB_T_REG) || (head_entry.rtype == ROB_T_JALR)) &&
                          (head_entry.rd != '0);
        commit_store_d  = (head_entry.rtype == ROB_T_ST);
        clear_all_d     = redirect;
        if (head_entry.rtype == ROB_T_JALR) begin
          new_pc_d = head_entry.jalr_pc;
        end else if (redirect) begin
          new_pc_d = head_entry.alt_pc;
        end
      end

      if (alloc_fire && !commit_fire) begin
        size_d = size_q + 1'b1;
      end else if (!alloc_fire && commit_fire) begin
        size_d = size_q - 1'b1;
      end

      // a redirect discards everything younger, including this cycle's issue/writeback
      if (flush) begin
        for (int i = 0; i < ROB_WIDTH; i++) begin
          entries_d[i].busy  = 1'b0;
          entries_d[i].ready = 1'b0;
        end
        head_d = '0;
        tail_d = '0;
        size_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ROB_WIDTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      size_q          <= '0;
      commit_reg_q    <= 1'b0;
      commit_store_q  <= 1'b0;
      clear_all_q     <= 1'b0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      commit_rob_id_q <= '0;
      new_pc_q        <= '0;
    end else begin
      entries_q       <= entries_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      size_q          <= size_d;
      commit_reg_q    <= commit_reg_d;
      commit_store_q  <= commit_store_d;
      clear_all_q     <= clear_all_d;
      commit_rd_q     <= commit_rd_d;
      commit_value_q  <= commit_value_d;
      commit_rob_id_q <= commit_rob_id_d;
      new_pc_q        <= new_pc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob.sv
// ============================================================================
// tb_rob: directed self-checking bench for the reorder buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rob;

  logic clk;
  logic rst;
  logic rdy;
  int   tests;
  int   fails;

  rob_if bus ();

  rob u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pt, input logic [31:0] alt);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = t;
    bus.issue_rd         = rd;
    bus.issue_pred_taken = pt;
    bus.issue_alt_pc     = alt;
  endtask

  task automatic rs_wb(input logic [3:0] id, input logic [31:0] v, input logic [31:0] npc);
    bus.rs_to_rob = 1'b1;
    bus.rs_rob_id = id;
    bus.rs_value  = v;
    bus.rs_new_pc = npc;
  endtask

  task automatic lsb_wb(input logic [3:0] id, input logic [31:0] v);
    bus.lsb_to_rob = 1'b1;
    bus.lsb_rob_id = id;
    bus.lsb_value  = v;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.rs_to_rob   = 1'b0;
    bus.lsb_to_rob  = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    rdy = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_type = 2'd0; bus.issue_rd = 5'd0;
    bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = 32'd0;
    bus.qry_j_id = 4'd0; bus.qry_k_id = 4'd0;
    bus.rs_to_rob = 1'b0; bus.rs_rob_id = 4'd0; bus.rs_value = 32'd0; bus.rs_new_pc = 32'd0;
    bus.lsb_to_rob = 1'b0; bus.lsb_rob_id = 4'd0; bus.lsb_value = 32'd0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_full",      bus.rob_full,      0);
    check("rst_alloc_id",  bus.alloc_id,      0);
    check("rst_commit",    bus.commit_reg,    0);
    check("rst_clear",     bus.clear_all,     0);
    check("rst_new_pc",    bus.new_pc,        0);

    // Single reg-write instruction, id0
    issue(2'd0, 5'd3, 1'b0, 32'd0);
    check("a_alloc_id", bus.alloc_id, 0);
    step();
    idle();
    bus.qry_j_id = 4'd0;
    #1 check("a_qry_not_ready", bus.qry_j_rdy, 0);
    rs_wb(4'd0, 32'h2A, 32'd0);
    step();
    idle();
    #1;
    check("a_qry_rdy", bus.qry_j_rdy, 1);
    check("a_qry_val", bus.qry_j_val, 32'h2A);
    check("a_no_commit_yet", bus.commit_reg, 0);
    step();
    check("a_commit_reg", bus.commit_reg,    1);
    check("a_commit_rd",  bus.commit_rd,     3);
    check("a_commit_val", bus.commit_value,  32'h2A);
    check("a_commit_id",  bus.commit_rob_id, 0);
    step();
    check("a_commit_pulse", bus.commit_reg, 0);

    // Out-of-order writeback, in-order retire (ids 1,2)
    issue(2'd0, 5'd5, 1'b0, 32'd0);
    step();
    issue(2'd0, 5'd6, 1'b0, 32'd0);
    step();
    idle();
    check("o_alloc_id", bus.alloc_id, 3);
    rs_wb(4'd2, 32'h22, 32'd0);
    step();
    idle();
    step();
    check("o_blocked", bus.commit_reg, 0);
    lsb_wb(4'd1, 32'h11);
    step();
    idle();
    step();
    check("o_first_reg", bus.commit_reg,    1);
    check("o_first_id",  bus.commit_rob_id, 1);
    check("o_first_val", bus.commit_value,  32'h11);
    step();
    check("o_second_reg", bus.commit_reg,    1);
    check("o_second_id",  bus.commit_rob_id, 2);
    check("o_second_rd",  bus.commit_rd,     6);
    check("o_second_val", bus.commit_value,  32'h22);

    // Same-cycle query vs writeback, id3
    issue(2'd0, 5'd7, 1'b0, 32'd0);
    step();
    idle();
    bus.qry_j_id = 4'd3;
    bus.qry_k_id = 4'd3;
    rs_wb(4'd3, 32'd7, 32'd0);
    #1;
`ifdef ROB_BYPASS_EN
    check("b_bypass_rdy", bus.qry_j_rdy, 1);
    check("b_bypass_val", bus.qry_j_val, 7);
`else
    check("b_nobypass_rdy", bus.qry_j_rdy, 0);
`endif
    step();
    idle();
    check("b_state_rdy", bus.qry_k_rdy, 1);
    check("b_state_val", bus.qry_k_val, 7);
    step();
    check("b_commit_rd", bus.commit_rd, 7);

    // rd==0 suppression (id4) and store release (id5)
    issue(2'd0, 5'd0, 1'b0, 32'd0);
    step();
    issue(2'd3, 5'd0, 1'b0, 32'd0);
    step();
    idle();
    rs_wb(4'd4, 32'd9, 32'd0);
    lsb_wb(4'd5, 32'd0);
    step();
    idle();
    step();
    check("z_rd0_suppressed", bus.commit_reg,    0);
    check("z_rd0_id",         bus.commit_rob_id, 4);
    step();
    check("s_store",    bus.commit_store,  1);
    check("s_store_id", bus.commit_rob_id, 5);
    check("s_no_reg",   bus.commit_reg,    0);
    step();
    check("s_store_pulse", bus.commit_store, 0);

    // Mispredicted branch id6 with younger id7; same-cycle issue is discarded
    issue(2'd1, 5'd0, 1'b0, 32'h1080);
    step();
    issue(2'd0, 5'd9, 1'b0, 32'd0);
    step();
    idle();
    rs_wb(4'd6, 32'd1, 32'd0);
    lsb_wb(4'd7, 32'h77);
    step();
    idle();
    issue(2'd0, 5'd10, 1'b0, 32'd0);
    step();
    idle();
    bus.qry_j_id = 4'd7;
    #1;
    check("m_clear",    bus.clear_all, 1);
    check("m_new_pc",   bus.new_pc,    32'h1080);
    check("m_alloc_id", bus.alloc_id,  0);
    check("m_full",     bus.rob_full,  0);
    check("m_young_dropped", bus.qry_j_rdy, 0);
    step();
    check("m_clear_pulse", bus.clear_all,  0);
    check("m_no_young",    bus.commit_reg, 0);

    // Correctly predicted branch id0: no redirect
    issue(2'd1, 5'd0, 1'b1, 32'h2000);
    step();
    idle();
    rs_wb(4'd0, 32'd1, 32'd0);
    step();
    idle();
    step();
    check("p_no_clear", bus.clear_all,     0);
    check("p_commit_id", bus.commit_rob_id, 0);

    // jalr id1 always redirects and writes the link value
    issue(2'd2, 5'd1, 1'b0, 32'd0);
    step();
    idle();
    rs_wb(4'd1, 32'h104, 32'h3000);
    step();
    idle();
    step();
    check("j_clear",  bus.clear_all,    1);
    check("j_new_pc", bus.new_pc,       32'h3000);
    check("j_reg",    bus.commit_reg,   1);
    check("j_val",    bus.commit_value, 32'h104);
    step();

    // Fill to 16 entries
    for (int i = 0; i < 15; i++) begin
      issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
      step();
    end
    check("f_not_full_15", bus.rob_full, 0);
    check("f_alloc_15",    bus.alloc_id, 15);
    step();
    check("f_full", bus.rob_full, 1);
    step();
    idle();
    check("f_ignored_full",  bus.rob_full, 1);
    check("f_ignored_alloc", bus.alloc_id, 0);
    rs_wb(4'd0, 32'd5, 32'd0);
    step();
    idle();
    step();
    check("f_after_commit_full", bus.rob_full,   0);
    check("f_commit_rd1",        bus.commit_rd,  1);
    rs_wb(4'd1, 32'd6, 32'd0);
    step();
    idle();
    issue(2'd0, 5'd20, 1'b0, 32'd0);
    step();
    check("f_alloc_commit_full", bus.rob_full,   0);
    check("f_alloc_commit_id",   bus.alloc_id,   1);
    check("f_commit_rd2",        bus.commit_rd,  2);
    step();
    idle();
    check("f_refull", bus.rob_full, 1);

    // Asynchronous reset mid-cycle with the buffer full
    #3 rst = 1'b1;
    #1;
    check("r_full",      bus.rob_full,      0);
    check("r_alloc_id",  bus.alloc_id,      0);
    check("r_commit_rd", bus.commit_rd,     0);
    check("r_value",     bus.commit_value,  0);
    check("r_new_pc",    bus.new_pc,        0);
    step();
    rst = 1'b0;

    // rdy_in low freezes state and pulse outputs
    issue(2'd0, 5'd4, 1'b0, 32'd0);
    step();
    idle();
    rs_wb(4'd0, 32'h55, 32'd0);
    step();
    idle();
    rdy = 1'b0;
    issue(2'd0, 5'd8, 1'b0, 32'd0);
    step();
    step();
    check("h_no_commit", bus.commit_reg, 0);
    check("h_no_alloc",  bus.alloc_id,   1);
    rdy = 1'b1;
    idle();
    step();
    check("h_commit",     bus.commit_reg,   1);
    check("h_commit_val", bus.commit_value, 32'h55);
    rdy = 1'b0;
    step();
    check("h_pulse_held", bus.commit_reg, 1);
    rdy = 1'b1;
    step();
    check("h_pulse_drop", bus.commit_reg, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
